// File: rtl/fm_buffer_sched_pkg.sv
// Shared types and sizing for the FM ping-pong buffer scheduler.
// Holds the per-buffer state enum and the width constants used on the ports.
package fm_buffer_sched_pkg;

    localparam int FM_BUFFER_COUNT_DEF = 2;
    localparam int FM_BUFFER_SIZE_DEF  = 32;

    localparam int INDICE_LEN    = $clog2(FM_BUFFER_SIZE_DEF);
    localparam int FM_BUF_ID_LEN = $clog2(FM_BUFFER_COUNT_DEF);
    localparam int FM_LEN_BITS   = INDICE_LEN + 1;

    typedef enum logic [1:0] {
        FM_FREE,
        FM_FILLING,
        FM_READY,
        FM_READING
    } fm_buf_state_e;

endpackage

// File: rtl/fm_buf_slot.sv
// One FM buffer slot: ownership state plus the stored valid length.
// Ports: fill/rd start and end strobes, len_in; flags is_free/is_ready/ready_next, len.
module fm_buf_slot
    import fm_buffer_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fill_start,
    input  logic                   fill_end,
    input  logic [FM_LEN_BITS-1:0] len_in,
    input  logic                   rd_start,
    input  logic                   rd_end,
    output logic                   is_free,
    output logic                   is_ready,
    output logic                   ready_next,
    output logic [FM_LEN_BITS-1:0] len
);

    fm_buf_state_e state;
    fm_buf_state_e state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FM_FREE;
        end else begin
            state <= state_next;
        end
    end

    // An empty fill hands the buffer straight back as FREE.
    always_comb begin
        state_next = state;
        unique case (state)
            FM_FREE:    if (fill_start) state_next = FM_FILLING;
            FM_FILLING: if (fill_end)
                            state_next = (len_in != '0) ? FM_READY : FM_FREE;
            FM_READY:   if (rd_start) state_next = FM_READING;
            FM_READING: if (rd_end) state_next = FM_FREE;
        endcase
    end

    always_comb begin
        is_free    = (state == FM_FREE);
        is_ready   = (state == FM_READY);
        ready_next = (state_next == FM_READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len <= '0;
        end else if (state == FM_FILLING && fill_end && len_in != '0) begin
            len <= len_in;
        end
    end

endmodule

// File: rtl/fm_buffer_sched.sv
// Ping-pong FM buffer scheduler between a loader (fill) and an extender (read).
// Ports: fill_req/grant/buf/done/len, rd_req/grant/buf/len/done, ready_cnt, frag_cnt, err.
module fm_buffer_sched
    import fm_buffer_sched_pkg::*;
#(
    parameter int FM_BUFFER_COUNT = FM_BUFFER_COUNT_DEF,
    parameter int FM_BUFFER_SIZE  = FM_BUFFER_SIZE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill_req,
    output logic                     fill_grant,
    output logic [FM_BUF_ID_LEN-1:0] fill_buf,
    input  logic                     fill_done,
    input  logic [FM_LEN_BITS-1:0]   fill_len,
    input  logic                     rd_req,
    output logic                     rd_grant,
    output logic [FM_BUF_ID_LEN-1:0] rd_buf,
    output logic [FM_LEN_BITS-1:0]   rd_len,
    input  logic                     rd_done,
    output logic [1:0]               ready_cnt,
    output logic [15:0]              frag_cnt,
    output logic                     err
);

    localparam logic [FM_LEN_BITS-1:0] SIZE_LEN = FM_LEN_BITS'(FM_BUFFER_SIZE);

    logic [FM_BUFFER_COUNT-1:0] slot_free;
    logic [FM_BUFFER_COUNT-1:0] slot_ready;
    logic [FM_BUFFER_COUNT-1:0] slot_ready_next;
    logic [FM_BUFFER_COUNT-1:0] fill_start;
    logic [FM_BUFFER_COUNT-1:0] fill_end;
    logic [FM_BUFFER_COUNT-1:0] rd_start;
    logic [FM_BUFFER_COUNT-1:0] rd_end;
    logic [FM_LEN_BITS-1:0]     slot_len [FM_BUFFER_COUNT];

    logic [FM_BUF_ID_LEN-1:0] wr_sel;
    logic [FM_BUF_ID_LEN-1:0] rd_sel;
    logic                     fill_busy;
    logic                     rd_busy;
    logic                     fill_go;
    logic                     rd_go;
    logic                     fill_ok;
    logic                     rd_ok;
    logic                     len_over;
    logic [FM_LEN_BITS-1:0]   len_store;
    logic [1:0]               ready_sum;

    assign fill_go   = fill_req & ~fill_busy & slot_free[wr_sel];
    assign rd_go     = rd_req & ~rd_busy & slot_ready[rd_sel];
    assign fill_ok   = fill_done & fill_busy;
    assign rd_ok     = rd_done & rd_busy;
    assign len_over  = (fill_len > SIZE_LEN);
    assign len_store = len_over ? SIZE_LEN : fill_len;

    for (genvar i = 0; i < FM_BUFFER_COUNT; i++) begin : g_slot
        localparam logic [FM_BUF_ID_LEN-1:0] ID = FM_BUF_ID_LEN'(i);

        assign fill_start[i] = fill_go & (wr_sel == ID);
        assign fill_end[i]   = fill_ok & (fill_buf == ID);
        assign rd_start[i]   = rd_go & (rd_sel == ID);
        assign rd_end[i]     = rd_ok & (rd_buf == ID);

        fm_buf_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .fill_start (fill_start[i]),
            .fill_end   (fill_end[i]),
            .len_in     (len_store),
            .rd_start   (rd_start[i]),
            .rd_end     (rd_end[i]),
            .is_free    (slot_free[i]),
            .is_ready   (slot_ready[i]),
            .ready_next (slot_ready_next[i]),
            .len        (slot_len[i])
        );
    end

    // Counted from next-state so the register lines up with the slot states.
    always_comb begin
        ready_sum = '0;
        for (int i = 0; i < FM_BUFFER_COUNT; i++) begin
            ready_sum = ready_sum + {1'b0, slot_ready_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_grant <= 1'b0;
            fill_buf   <= '0;
            fill_busy  <= 1'b0;
            wr_sel     <= '0;
            rd_grant   <= 1'b0;
            rd_buf     <= '0;
            rd_len     <= '0;
            rd_busy    <= 1'b0;
            rd_sel     <= '0;
            ready_cnt  <= '0;
            frag_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            fill_grant <= fill_go;
            rd_grant   <= rd_go;
            ready_cnt  <= ready_sum;

            if (fill_go) begin
                fill_busy <= 1'b1;
                fill_buf  <= wr_sel;
            end else if (fill_ok) begin
                fill_busy <= 1'b0;
                if (fill_len != '0) wr_sel <= ~wr_sel;
            end

            if (rd_go) begin
                rd_busy <= 1'b1;
                rd_buf  <= rd_sel;
                rd_len  <= slot_len[rd_sel];
            end else if (rd_ok) begin
                rd_busy <= 1'b0;
                rd_sel  <= ~rd_sel;
                if (frag_cnt != 16'hFFFF) frag_cnt <= frag_cnt + 16'd1;
            end

            if ((fill_done & ~fill_busy) | (rd_done & ~rd_busy) |
                (fill_ok & len_over)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fm_buffer_sched.sv
// Bench for fm_buffer_sched: queue-based reference model plus directed checks.
// Random loader/extender agents drive the DUT; outputs compared every cycle.
module tb_fm_buffer_sched;
    import fm_buffer_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fill_req = 1'b0;
    logic        fill_grant;
    logic        fill_buf;
    logic        fill_done = 1'b0;
    logic [5:0]  fill_len = '0;
    logic        rd_req = 1'b0;
    logic        rd_grant;
    logic        rd_buf;
    logic [5:0]  rd_len;
    logic        rd_done = 1'b0;
    logic [1:0]  ready_cnt;
    logic [15:0] frag_cnt;
    logic        err;

    fm_buffer_sched dut (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .fill_grant (fill_grant),
        .fill_buf   (fill_buf),
        .fill_done  (fill_done),
        .fill_len   (fill_len),
        .rd_req     (rd_req),
        .rd_grant   (rd_grant),
        .rd_buf     (rd_buf),
        .rd_len     (rd_len),
        .rd_done    (rd_done),
        .ready_cnt  (ready_cnt),
        .frag_cnt   (frag_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endfunction

    // Reference model: READY buffers as an ordered queue of (id, len).
    bit m_fown, m_rown, m_wr, m_fid;
    int q_id[$];
    int q_len[$];
    int e_fg, e_fb, e_rg, e_rb, e_rl, e_rc, e_fc, e_err;

    function automatic void m_reset();
        m_fown = 0; m_rown = 0; m_wr = 0; m_fid = 0;
        q_id.delete(); q_len.delete();
        e_fg = 0; e_fb = 0; e_rg = 0; e_rb = 0;
        e_rl = 0; e_rc = 0; e_fc = 0; e_err = 0;
    endfunction

    function automatic bit m_free(int b);
        if (m_fown && m_fid == b) return 0;
        if (m_rown && e_rb == b) return 0;
        foreach (q_id[k]) if (q_id[k] == b) return 0;
        return 1;
    endfunction

    function automatic void m_step(bit r, bit fr, bit fd, int fl,
                                   bit rr, bit rd);
        bit gf, gr, fok, rok;
        if (r) begin
            m_reset();
            return;
        end
        gf  = fr && !m_fown && m_free(int'(m_wr));
        gr  = rr && !m_rown && q_id.size() > 0;
        fok = fd && m_fown;
        rok = rd && m_rown;
        if (fd && !fok) e_err = 1;
        if (rd && !rok) e_err = 1;
        if (gr) begin
            e_rb = q_id.pop_front();
            e_rl = q_len.pop_front();
            m_rown = 1;
        end
        if (fok) begin
            m_fown = 0;
            if (fl > 32) e_err = 1;
            if (fl > 0) begin
                q_id.push_back(int'(m_fid));
                q_len.push_back(fl > 32 ? 32 : fl);
                m_wr = !m_wr;
            end
        end
        if (rok) begin
            m_rown = 0;
            if (e_fc < 65535) e_fc++;
        end
        if (gf) begin
            m_fown = 1;
            m_fid = m_wr;
            e_fb = int'(m_wr);
        end
        e_fg = int'(gf);
        e_rg = int'(gr);
        e_rc = q_id.size();
    endfunction

    initial m_reset();

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("fill_grant", int'(fill_grant), e_fg);
            chk("fill_buf", int'(fill_buf), e_fb);
            chk("rd_grant", int'(rd_grant), e_rg);
            chk("rd_buf", int'(rd_buf), e_rb);
            chk("rd_len", int'(rd_len), e_rl);
            chk("ready_cnt", int'(ready_cnt), e_rc);
            chk("frag_cnt", int'(frag_cnt), e_fc);
            chk("err", int'(err), e_err);
        end
    end

    task automatic cyc(bit r, bit fr, bit fd, int fl, bit rr, bit rd);
        @(negedge clk);
        rst = r;
        fill_req = fr;
        fill_done = fd;
        fill_len = 6'(fl);
        rd_req = rr;
        rd_done = rd;
        m_step(r, fr, fd, fl, rr, rd);
        chk_on = 1;
        @(posedge clk);
        #2;
    endtask

    function automatic int pick_len();
        int s;
        s = $urandom_range(0, 15);
        if (s == 0) return 0;
        if (s == 1) return $urandom_range(33, 63);
        return $urandom_range(1, 32);
    endfunction

    bit l_req, l_own, x_req, x_own;
    int l_wait, x_wait;
    bit rr_r, rr_fd, rr_rd;
    int rr_fl, g;

    initial begin
        // Basic fill then read.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_fg", int'(fill_grant), 0);
        chk("rst_ready", int'(ready_cnt), 0);
        chk("rst_frag", int'(frag_cnt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rdlen", int'(rd_len), 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("b_fg", int'(fill_grant), 1);
        chk("b_fb", int'(fill_buf), 0);
        cyc(0, 0, 1, 32, 0, 0);
        chk("b_ready", int'(ready_cnt), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("b_rg", int'(rd_grant), 1);
        chk("b_rb", int'(rd_buf), 0);
        chk("b_rl", int'(rd_len), 32);
        cyc(0, 0, 0, 0, 0, 1);
        chk("b_frag", int'(frag_cnt), 1);

        // Full: two READY buffers stall further fills.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("f_fb0", int'(fill_buf), 0);
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("f_fg1", int'(fill_grant), 1);
        chk("f_fb1", int'(fill_buf), 1);
        cyc(0, 0, 1, 9, 0, 0);
        chk("f_ready2", int'(ready_cnt), 2);
        g = 0;
        repeat (20) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (fill_grant) g++;
        end
        chk("f_nogrant", g, 0);
        chk("f_err", int'(err), 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("f_rl5", int'(rd_len), 5);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("f_rb1", int'(rd_buf), 1);
        chk("f_rl9", int'(rd_len), 9);
        cyc(0, 0, 0, 0, 0, 1);
        chk("f_frag2", int'(frag_cnt), 2);

        // Streaming with overlapping fill_done/rd_done.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, i < 9, 0, 0, 1, 0);
            chk("s_rg", int'(rd_grant), 1);
            chk("s_rb", int'(rd_buf), i % 2);
            chk("s_rl", int'(rd_len), i + 3);
            if (i < 9) chk("s_fb", int'(fill_buf), (i + 1) % 2);
            cyc(0, 0, i < 9, i + 4, 0, 1);
        end
        chk("s_frag10", int'(frag_cnt), 10);
        chk("s_ready0", int'(ready_cnt), 0);

        // Zero length and oversized length.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("z_ready0", int'(ready_cnt), 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("z_fg", int'(fill_grant), 1);
        chk("z_fb0", int'(fill_buf), 0);
        cyc(0, 0, 1, 40, 0, 0);
        chk("o_err", int'(err), 1);
        chk("o_ready1", int'(ready_cnt), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("o_rl32", int'(rd_len), 32);

        // Stray done, then reset mid-fill.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("x_err", int'(err), 1);
        chk("x_frag0", int'(frag_cnt), 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 7, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("x_fb1", int'(fill_buf), 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("x_rst_fb", int'(fill_buf), 0);
        chk("x_rst_ready", int'(ready_cnt), 0);
        chk("x_rst_err", int'(err), 0);
        cyc(0, 0, 1, 4, 0, 0);
        chk("x_stray_err", int'(err), 1);
        chk("x_stray_ready", int'(ready_cnt), 0);

        // Random agents.
        cyc(1, 0, 0, 0, 0, 0);
        l_req = 0; l_own = 0; x_req = 0; x_own = 0;
        l_wait = 0; x_wait = 0;
        for (int n = 0; n < 3000; n++) begin
            rr_r = 0; rr_fd = 0; rr_rd = 0; rr_fl = 0;
            if (e_fg != 0) begin
                l_req = 0; l_own = 1; l_wait = $urandom_range(0, 4);
            end
            if (e_rg != 0) begin
                x_req = 0; x_own = 1; x_wait = $urandom_range(0, 6);
            end
            if (l_own) begin
                if (l_wait == 0) begin
                    rr_fd = 1; rr_fl = pick_len(); l_own = 0;
                end else l_wait--;
            end else begin
                if (!l_req && $urandom_range(0, 3) == 0) l_req = 1;
                if ($urandom_range(0, 63) == 0) begin
                    rr_fd = 1; rr_fl = pick_len();
                end
            end
            if (x_own) begin
                if (x_wait == 0) begin
                    rr_rd = 1; x_own = 0;
                end else x_wait--;
            end else begin
                if (!x_req && $urandom_range(0, 2) == 0) x_req = 1;
                if ($urandom_range(0, 63) == 0) rr_rd = 1;
            end
            if ($urandom_range(0, 499) == 0) begin
                rr_r = 1;
                l_req = 0; l_own = 0; x_req = 0; x_own = 0;
            end
            cyc(rr_r, l_req, rr_fd, rr_fl, x_req, rr_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
